// File: rtl/little_cpu_pkg.sv
// Shared types and default widths for the little CPU memory path.
package little_cpu_pkg;

    localparam int DEF_BITS      = 8;
    localparam int DEF_ADDR_BITS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_LDR = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker with a loader lock that holds priority once the loader owns the port.
module arb_rr2
    import little_cpu_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    input  logic       lock,
    output owner_t     winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = REQ_CPU;
        if (lock && (last_owner == REQ_LDR) && req[1]) begin
            winner = REQ_LDR;
        end else if (&req) begin
            // tie goes to whoever did not own the last access
            winner = (last_owner == REQ_CPU) ? REQ_LDR : REQ_CPU;
        end else if (req[1]) begin
            winner = REQ_LDR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM port between the CPU MAR/MDR path and the loader/debug port.
//   state  | meaning
//   IDLE   | sample requests, capture the winner
//   ACCESS | drive the captured access onto the RAM port
//   RESP   | latch read data for the owner, then raise done
module mem_arbiter
    import little_cpu_pkg::*;
#(
    parameter int BITS      = DEF_BITS,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cpu_req,
    input  logic                 i_cpu_we,
    input  logic [ADDR_BITS-1:0] i_cpu_addr,
    input  logic [BITS-1:0]      i_cpu_wdata,
    output logic                 o_cpu_gnt,
    output logic                 o_cpu_done,
    output logic [BITS-1:0]      o_cpu_rdata,
    input  logic                 i_ldr_req,
    input  logic                 i_ldr_we,
    input  logic [ADDR_BITS-1:0] i_ldr_addr,
    input  logic [BITS-1:0]      i_ldr_wdata,
    input  logic                 i_ldr_lock,
    output logic                 o_ldr_gnt,
    output logic                 o_ldr_done,
    output logic [BITS-1:0]      o_ldr_rdata,
    output logic                 o_mem_en,
    output logic                 o_mem_we,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [BITS-1:0]      o_mem_wdata,
    input  logic [BITS-1:0]      i_mem_rdata
);

    arb_state_t           state, next_state;
    owner_t               last_owner, cap_owner, winner;
    logic                 valid, capture;
    logic                 cap_we;
    logic [ADDR_BITS-1:0] cap_addr;
    logic [BITS-1:0]      cap_wdata;

    arb_rr2 u_rr (
        .req        ({i_ldr_req, i_cpu_req}),
        .last_owner (last_owner),
        .lock       (i_ldr_lock),
        .winner     (winner),
        .valid      (valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    capture    = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_owner  <= REQ_LDR;
            cap_owner   <= REQ_CPU;
            cap_we      <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            o_cpu_gnt   <= 1'b0;
            o_ldr_gnt   <= 1'b0;
            o_cpu_done  <= 1'b0;
            o_ldr_done  <= 1'b0;
            o_cpu_rdata <= '0;
            o_ldr_rdata <= '0;
        end else begin
            o_cpu_gnt  <= capture && (winner == REQ_CPU);
            o_ldr_gnt  <= capture && (winner == REQ_LDR);
            o_cpu_done <= (state == RESP) && (cap_owner == REQ_CPU);
            o_ldr_done <= (state == RESP) && (cap_owner == REQ_LDR);
            if (capture) begin
                last_owner <= winner;
                cap_owner  <= winner;
                cap_we     <= (winner == REQ_LDR) ? i_ldr_we    : i_cpu_we;
                cap_addr   <= (winner == REQ_LDR) ? i_ldr_addr  : i_cpu_addr;
                cap_wdata  <= (winner == REQ_LDR) ? i_ldr_wdata : i_cpu_wdata;
            end
            if ((state == RESP) && !cap_we) begin
                if (cap_owner == REQ_LDR) o_ldr_rdata <= i_mem_rdata;
                else                      o_cpu_rdata <= i_mem_rdata;
            end
        end
    end

    // the RAM port is quiet outside ACCESS so it never sees stale capture values
    always_comb begin
        o_mem_en    = (state == ACCESS);
        o_mem_we    = o_mem_en && cap_we;
        o_mem_addr  = o_mem_en ? cap_addr  : '0;
        o_mem_wdata = o_mem_en ? cap_wdata : '0;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the CPU's single synchronous memory port between two requesters: the CPU fetch/execute path (MAR/MDR side of the control sequencer) and the program loader/debug port. It arbitrates round-robin, with an optional loader lock for burst loading. It registers the winning request, drives one memory access, and returns read data with a done pulse. It sits between the datapath's MAR/MDR logic and the RAM.

## Interface
- BITS, 8, data word width (matches CPU datapath)
- ADDR_BITS, 8, memory address width
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_cpu_req  in  1  CPU requests an access
- i_cpu_we  in  1  1 = write, 0 = read
- i_cpu_addr  in  ADDR_BITS  CPU address (from MAR)
- i_cpu_wdata  in  BITS  CPU write data (from MDR)
- o_cpu_gnt  out  1  one-cycle pulse: CPU request captured
- o_cpu_done  out  1  one-cycle pulse: CPU access complete
- o_cpu_rdata  out  BITS  CPU read data, valid with o_cpu_done
- i_ldr_req, i_ldr_we, i_ldr_addr, i_ldr_wdata  in  1/1/ADDR_BITS/BITS  loader request, same meaning as the CPU signals
- i_ldr_lock  in  1  loader keeps priority while high
- o_ldr_gnt, o_ldr_done, o_ldr_rdata  out  1/1/BITS  loader responses, same meaning as the CPU signals
- o_mem_en  out  1  memory access strobe
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_BITS  memory address
- o_mem_wdata  out  BITS  memory write data
- i_mem_rdata  in  BITS  RAM read data, valid one cycle after o_mem_en

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE: requests are sampled only here. If any request is high, capture the winner's we/addr/wdata and owner ID into registers, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS: o_mem_en=1. o_mem_we, o_mem_addr and o_mem_wdata come from the capture registers. Then go to RESP.
- RESP: on a read, latch i_mem_rdata into the owner's rdata register. On a write, rdata keeps its old value. Then go to IDLE.
- Arbitration: one request wins outright. On a tie, the requester that is not last_owner wins. last_owner updates on every capture.
- Lock: if i_ldr_lock=1, last_owner=LDR, and i_ldr_req=1, the loader wins regardless of the CPU. The lock never preempts an access in flight.
- Requests are ignored in ACCESS and RESP; they stay pending at the requester.
- A request still high in the done cycle (state back in IDLE) counts as a new access. This is legal and gives back-to-back accesses.
- Address and data are captured at grant. Changes on i_*_addr/wdata after capture do not affect the access.
- Memory outputs are 0 whenever state ≠ ACCESS.
- Reset values: state=IDLE, last_owner=LDR (so the CPU wins the first tie), all gnt/done/mem outputs 0, both rdata registers 0.
- Reset mid-operation: the in-flight access is abandoned. No done pulse is produced, and no write occurs unless the ACCESS edge has already passed.

## Timing
- Cycle 0: IDLE with a request present. The capture happens at the end of cycle 0.
- Cycle 1: ACCESS. o_*_gnt is high (registered pulse) and o_mem_en is high. The RAM acts at the end of cycle 1.
- Cycle 2: RESP. i_mem_rdata is valid and is latched at the end of the cycle.
- Cycle 3: IDLE. o_*_done is high and o_*_rdata is valid; rdata holds until the owner's next read.
- Latency from request seen to done is 3 cycles. Peak throughput is one access per 3 cycles.
- gnt and done are single-cycle pulses, exclusive between requesters.
- gnt and done are never both high for the same requester.

## Structure
- Shared package little_cpu_pkg holds:
  - arb_state_t enum (IDLE, ACCESS, RESP)
  - owner_t with constants REQ_CPU=0, REQ_LDR=1
  - default BITS and ADDR_BITS constants
- One sub-module, arb_rr2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_owner, lock.
  - Outputs: winner, valid.
- FSM, capture registers and response registers stay in mem_arbiter.

## Test plan
- CPU read alone: model RAM[0x10]=0xA5; CPU req, we=0, addr=0x10 at cycle 0 -> o_cpu_gnt in cycle 1, o_mem_en with addr 0x10 in cycle 1, o_cpu_done in cycle 3 with o_cpu_rdata=0xA5; all loader outputs stay 0.
- Loader write then CPU read: loader writes 0x3C to 0x20, then CPU reads 0x20 -> memory sees we=1, addr=0x20, wdata=0x3C; CPU rdata=0x3C; the write leaves o_ldr_rdata unchanged.
- Simultaneous requests held high for 4 accesses after reset -> grant order CPU, LDR, CPU, LDR, each done 3 cycles after its capture.
- Lock burst: i_ldr_lock=1 with both requests held, loader wins once -> loader wins the next 3 captures in a row; lock dropped -> the CPU wins the next tie.
- Reset in ACCESS: i_rst high during cycle 1 of a CPU read -> next cycle IDLE, o_mem_en=0, no o_cpu_done, rdata=0; a fresh request afterwards completes normally.
- Address change after grant: CPU addr changes from 0x05 to 0x06 in cycle 1 -> memory still sees 0x05.
